// File: rtl/sram_port_arbiter_if.sv
// Purpose : request/response bus between two requesters and the SRAM RW-port arbiter.
// Latency : n/a (wires only); response arrives one cycle after the grant.
// Backpr. : request side is valid/ready; response side has no back-pressure.
// Ports (signal names are seen from the arbiter, so _i = into arbiter):
//   req_valid_i[1:0], req_we_i[1:0], req_wmask_i, req_addr_i, req_wdata_i (slice i = requester i)
//   req_ready_o[1:0] grant, rsp_valid_o[1:0] one-cycle response strobe, rsp_rdata_o shared read data
interface sram_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_WMASKS = 4
);
  logic [1:0]              req_valid_i;
  logic [1:0]              req_ready_o;
  logic [1:0]              req_we_i;
  logic [2*NUM_WMASKS-1:0] req_wmask_i;
  logic [2*ADDR_WIDTH-1:0] req_addr_i;
  logic [2*DATA_WIDTH-1:0] req_wdata_i;
  logic [1:0]              rsp_valid_o;
  logic [DATA_WIDTH-1:0]   rsp_rdata_o;

  // Arbiter side.
  modport slave (
    input  req_valid_i, req_we_i, req_wmask_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o
  );

  // Requester side.
  modport master (
    output req_valid_i, req_we_i, req_wmask_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Purpose : two-requester arbiter/sequencer for the RW port (port 0) of an OpenRAM-style SRAM macro.
// Latency : grant same cycle as valid; fixed 1-cycle response (read data or write ack).
// Backpr. : valid/ready on requests, burst-limited to MAX_BURST under contention; responses cannot stall.
// Ports   : clk_i, rst_i (synchronous, active high); bus (sram_port_arbiter_if.slave);
//           sram_csb_o/web_o (active low), sram_wmask_o, sram_addr_o, sram_wdata_o to the macro;
//           sram_rdata_i from macro dout0.
// Config  : define SRAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins, 1 may starve).
module sram_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_WMASKS = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sram_port_arbiter_if.slave    bus,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [NUM_WMASKS-1:0] sram_wmask_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  // Requests are ignored entirely while in reset.
  logic [1:0] vld;
  logic       gnt;
  logic       win;

  assign vld = rst_i ? 2'b00 : bus.req_valid_i;
  assign gnt = |vld;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it asks.
  assign win = ~vld[0];
`else
  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  logic             owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  // Owner keeps the port under contention until its burst budget is spent.
  always_comb begin
    if (vld == 2'b11) win = (burst_cnt_q == CNT_MAX) ? ~owner_q : owner_q;
    else              win = vld[1];
  end

  // Count saturates so a lone requester never wraps back into an unearned budget.
  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = '0;
    if (gnt) begin
      if (win == owner_q) begin
        burst_cnt_d = (burst_cnt_q == CNT_MAX) ? CNT_MAX : burst_cnt_q + CNT_W'(1);
      end else begin
        owner_d     = win;
        burst_cnt_d = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q     <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
`endif

  // Winner's request fields.
  logic                  sel_we;
  logic [NUM_WMASKS-1:0] sel_wmask;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign sel_we    = win ? bus.req_we_i[1] : bus.req_we_i[0];
  assign sel_wmask = win ? bus.req_wmask_i[2*NUM_WMASKS-1:NUM_WMASKS] : bus.req_wmask_i[NUM_WMASKS-1:0];
  assign sel_addr  = win ? bus.req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]  : bus.req_addr_i[ADDR_WIDTH-1:0];
  assign sel_wdata = win ? bus.req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : bus.req_wdata_i[DATA_WIDTH-1:0];

  assign bus.req_ready_o = !gnt ? 2'b00 : (win ? 2'b10 : 2'b01);

  // Macro drive; everything parks at its idle value when no grant is issued.
  // Reads force the mask to zero so the macro never sees a stray write enable pattern.
  assign sram_csb_o   = ~gnt;
  assign sram_web_o   = ~(gnt & sel_we);
  assign sram_wmask_o = (gnt & sel_we) ? sel_wmask : '0;
  assign sram_addr_o  = gnt ? sel_addr  : '0;
  assign sram_wdata_o = gnt ? sel_wdata : '0;

  // Pending-response tracking for the access sampled by the macro this cycle.
  logic rsp_pend_q, rsp_pend_d;
  logic rsp_idx_q, rsp_idx_d;
  logic rsp_is_rd_q, rsp_is_rd_d;

  assign rsp_pend_d  = gnt;
  assign rsp_idx_d   = win;
  assign rsp_is_rd_d = gnt & ~sel_we;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_pend_q  <= 1'b0;
      rsp_idx_q   <= 1'b0;
      rsp_is_rd_q <= 1'b0;
    end else begin
      rsp_pend_q  <= rsp_pend_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_is_rd_q <= rsp_is_rd_d;
    end
  end

  // Reset asserted in the response cycle kills the strobe even though the state
  // register has not cleared yet.
  logic rsp_live;
  assign rsp_live = rsp_pend_q & ~rst_i;

  assign bus.rsp_valid_o = !rsp_live ? 2'b00 : (rsp_idx_q ? 2'b10 : 2'b01);
  // dout0 is only meaningful after a read; write acks return zero.
  assign bus.rsp_rdata_o = (rsp_live & rsp_is_rd_q) ? sram_rdata_i : '0;

endmodule
